// File: rtl/rs_dec_syndrome_gen.sv
// rs_dec_syndrome_gen
//   Reed-Solomon syndrome generator for the CD C1/C2 decode chain. Takes
//   NLEN-symbol frames from the EFM LUT decoder. It evaluates the received
//   polynomial at alpha^0..alpha^(NSYM-1) using Horner's rule, with constant
//   GF(2^8) multipliers. Each result is handed to the Euclid solver through
//   a one-deep valid/ready output register.
//
//   Optional feature: define RS_SYND_ERASURE_EN to add the i_erasure input
//   and the o_era_cnt output. The counter counts flagged symbols per frame.
//   A frame is reported error-free only when it has no syndromes and no
//   erasures.
//
//   Handshake: a result is transferred on any rising edge where o_valid and
//   i_ready are both high. o_valid then drops on the next cycle, unless a new
//   frame completes on that same edge. While o_valid is high and i_ready is
//   low, o_synd and o_err_free are held stable. If a new frame completes in
//   that state, it replaces the held result and o_ovf pulses.
module rs_dec_syndrome_gen #(
  parameter int         NSYM    = 4,
  parameter int         NLEN    = 32,
  parameter logic [8:0] GF_POLY = 9'h11D
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_frame_sync,
  input  logic [7:0]                i_data,
  input  logic                      i_data_sync,
`ifdef RS_SYND_ERASURE_EN
  input  logic                      i_erasure,
  output logic [$clog2(NLEN+1)-1:0] o_era_cnt,
`endif
  output logic [8*NSYM-1:0]         o_synd,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_err_free,
  output logic                      o_len_err,
  output logic                      o_ovf,
  output logic [1:0]                o_dbg_state
);

  localparam int CW = $clog2(NLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(NLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1
  } state_t;

  // Multiply by alpha (x) modulo the field polynomial.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
  endfunction

  // alpha^e. Only ever called with elaboration-time constants.
  function automatic logic [7:0] gf_alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = gf_xtime(r);
    return r;
  endfunction

  // General shift-and-add product. Because b is always a constant root,
  // this reduces to a fixed XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) r = gf_xtime(r) ^ (b[i] ? a : 8'h00);
    return r;
  endfunction

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [NSYM-1:0][7:0]       acc_q, acc_d;
  logic [NSYM-1:0][7:0]       step;
  logic [NSYM-1:0][7:0]       synd_q, synd_d;
  logic                       valid_q, valid_d;
  logic                       err_free_q, err_free_d;
  logic                       len_err_q, len_err_d;
  logic                       ovf_q, ovf_d;
  logic                       complete;
  logic                       final_clean;

  // One Horner step per syndrome: S_j * alpha^j + r.
  for (genvar j = 0; j < NSYM; j++) begin : g_horner
    localparam logic [7:0] ALPHA_J = gf_alpha_pow(j);
    assign step[j] = gf_mul(acc_q[j], ALPHA_J) ^ i_data;
  end

`ifdef RS_SYND_ERASURE_EN
  localparam int EW = $clog2(NLEN + 1);
  logic [EW-1:0] era_q, era_d;
  logic [EW-1:0] era_step;
  logic [EW-1:0] era_out_q, era_out_d;

  assign era_step    = era_q + (i_erasure ? EW'(1) : EW'(0));
  assign final_clean = (step == '0) && (era_step == '0);
  assign o_era_cnt   = era_out_q;
`else
  assign final_clean = (step == '0);
`endif

  // Frame FSM. It also produces the next accumulator, counter and error state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    len_err_d = 1'b0;
    complete  = 1'b0;
`ifdef RS_SYND_ERASURE_EN
    era_d     = era_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_frame_sync) begin
          state_d = ST_ACC;
          acc_d   = i_data_sync ? {NSYM{i_data}} : '0;
          cnt_d   = i_data_sync ? CW'(1) : '0;
`ifdef RS_SYND_ERASURE_EN
          era_d   = (i_data_sync && i_erasure) ? EW'(1) : '0;
`endif
        end
      end
      ST_ACC: begin
        if (i_data_sync && (cnt_q == CNT_LAST)) begin
          // The final strobe belongs to the closing frame. A coincident
          // frame sync opens an empty frame and is not a length error.
          complete = 1'b1;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = i_frame_sync ? ST_ACC : ST_IDLE;
`ifdef RS_SYND_ERASURE_EN
          era_d    = '0;
`endif
        end else if (i_frame_sync) begin
          // Early sync: drop the partial frame and restart.
          len_err_d = (cnt_q != '0);
          state_d   = ST_ACC;
          acc_d     = i_data_sync ? {NSYM{i_data}} : '0;
          cnt_d     = i_data_sync ? CW'(1) : '0;
`ifdef RS_SYND_ERASURE_EN
          era_d     = (i_data_sync && i_erasure) ? EW'(1) : '0;
`endif
        end else if (i_data_sync) begin
          acc_d = step;
          cnt_d = cnt_q + CW'(1);
`ifdef RS_SYND_ERASURE_EN
          era_d = era_step;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: load on completion, otherwise release on accept.
  always_comb begin
    synd_d     = synd_q;
    valid_d    = valid_q;
    err_free_d = err_free_q;
    ovf_d      = 1'b0;
`ifdef RS_SYND_ERASURE_EN
    era_out_d  = era_out_q;
`endif
    if (complete) begin
      synd_d     = step;
      valid_d    = 1'b1;
      err_free_d = final_clean;
      ovf_d      = valid_q && !i_ready;
`ifdef RS_SYND_ERASURE_EN
      era_out_d  = era_step;
`endif
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      synd_q     <= '0;
      valid_q    <= 1'b0;
      err_free_q <= 1'b0;
      len_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef RS_SYND_ERASURE_EN
      era_q      <= '0;
      era_out_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      synd_q     <= synd_d;
      valid_q    <= valid_d;
      err_free_q <= err_free_d;
      len_err_q  <= len_err_d;
      ovf_q      <= ovf_d;
`ifdef RS_SYND_ERASURE_EN
      era_q      <= era_d;
      era_out_q  <= era_out_d;
`endif
    end
  end

  assign o_synd      = synd_q;
  assign o_valid     = valid_q;
  assign o_err_free  = err_free_q;
  assign o_len_err   = len_err_q;
  assign o_ovf       = ovf_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_rs_dec_syndrome_gen.sv
// Directed bench for rs_dec_syndrome_gen. It instantiates two DUTs on shared
// stimulus: NLEN=32 (C1) and NLEN=28 (C2).
module tb_rs_dec_syndrome_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic [7:0]  dat;
  logic        ds;
  logic        rdy;

  logic [31:0] synd32, synd28;
  logic        v32, v28, ef32, ef28, le32, le28, ovf32, ovf28;
  logic [1:0]  st32, st28;
`ifdef RS_SYND_ERASURE_EN
  logic        era;
  logic [5:0]  era_cnt32;
  logic [4:0]  era_cnt28;
`endif

  int nchk = 0;
  int nerr = 0;

  // Pulse / rising-edge tallies, sampled on the inactive edge.
  int n_len_err = 0;
  int n_ovf     = 0;
  int n_vrise   = 0;
  logic v32_prev = 1'b0;

  rs_dec_syndrome_gen #(.NSYM(4), .NLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_sync(fs), .i_data(dat), .i_data_sync(ds),
`ifdef RS_SYND_ERASURE_EN
    .i_erasure(era), .o_era_cnt(era_cnt32),
`endif
    .o_synd(synd32), .o_valid(v32), .i_ready(rdy), .o_err_free(ef32),
    .o_len_err(le32), .o_ovf(ovf32), .o_dbg_state(st32)
  );

  rs_dec_syndrome_gen #(.NSYM(4), .NLEN(28)) dut28 (
    .i_clk(clk), .i_rst(rst), .i_frame_sync(fs), .i_data(dat), .i_data_sync(ds),
`ifdef RS_SYND_ERASURE_EN
    .i_erasure(era), .o_era_cnt(era_cnt28),
`endif
    .o_synd(synd28), .o_valid(v28), .i_ready(rdy), .o_err_free(ef28),
    .o_len_err(le28), .o_ovf(ovf28), .o_dbg_state(st28)
  );

  // Clock
  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    if (le32) n_len_err++;
    if (ovf32) n_ovf++;
    if (v32 && !v32_prev) n_vrise++;
    v32_prev = v32;
  end

  // Golden power of alpha for GF(2^8)/0x11D, by repeated doubling.
  function automatic logic [7:0] alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h1D) : {r[6:0], 1'b0};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic f, input logic [7:0] d);
    fs = f; ds = 1'b1; dat = d;
    tick();
    fs = 1'b0; ds = 1'b0; dat = 8'h00;
  endtask

  task automatic sync_only();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    nchk++; if (synd32 !== 32'h0 || v32 !== 1'b0 || ef32 !== 1'b0) begin
      nerr++; $display("FAIL reset_out32: synd=%h valid=%b ef=%b expected 0/0/0", synd32, v32, ef32); end
    nchk++; if (le32 !== 1'b0 || ovf32 !== 1'b0 || st32 !== 2'd0) begin
      nerr++; $display("FAIL reset_pulse32: len_err=%b ovf=%b st=%0d expected 0/0/0", le32, ovf32, st32); end
    nchk++; if (synd28 !== 32'h0 || v28 !== 1'b0 || ef28 !== 1'b0) begin
      nerr++; $display("FAIL reset_out28: synd=%h valid=%b ef=%b expected 0/0/0", synd28, v28, ef28); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_frame();
    sync_only();
    for (int i = 0; i < 31; i++) strobe(1'b0, 8'h00);
    nchk++; if (v32 !== 1'b0) begin
      nerr++; $display("FAIL zero_early_valid: got %b expected 0", v32); end
    strobe(1'b0, 8'h00);
    nchk++; if (v32 !== 1'b1 || synd32 !== 32'h0 || ef32 !== 1'b1) begin
      nerr++; $display("FAIL zero_frame: valid=%b synd=%h ef=%b expected 1/00000000/1", v32, synd32, ef32); end
    tick();
    nchk++; if (v32 !== 1'b0) begin
      nerr++; $display("FAIL zero_accept_drop: valid=%b expected 0", v32); end
  endtask

  task automatic test_horner();
    logic [31:0] exp_s;
    // Single nonzero last symbol: every syndrome equals it.
    strobe(1'b1, 8'h00);
    for (int i = 1; i < 31; i++) strobe(1'b0, 8'h00);
    strobe(1'b0, 8'h5A);
    nchk++; if (synd32 !== 32'h5A5A5A5A || ef32 !== 1'b0 || v32 !== 1'b1) begin
      nerr++; $display("FAIL last_5a: synd=%h ef=%b valid=%b expected 5a5a5a5a/0/1", synd32, ef32, v32); end
    tick();
    // 0x01 first: S_j = alpha^(31j).
    for (int j = 0; j < 4; j++) exp_s[8*j +: 8] = alpha_pow(31 * j);
    strobe(1'b1, 8'h01);
    for (int i = 1; i < 32; i++) strobe(1'b0, 8'h00);
    nchk++; if (synd32 !== exp_s || ef32 !== 1'b0) begin
      nerr++; $display("FAIL first_01: synd=%h ef=%b expected %h/0", synd32, ef32, exp_s); end
    nchk++; if (synd32[15:8] !== 8'hC0) begin
      nerr++; $display("FAIL alpha31: S1=%h expected c0", synd32[15:8]); end
    tick();
  endtask

  task automatic test_len_err();
    int le0, vr0;
    le0 = n_len_err; vr0 = n_vrise;
    sync_only();
    for (int i = 0; i < 10; i++) strobe(1'b0, 8'h77);
    sync_only();
    nchk++; if (le32 !== 1'b1) begin
      nerr++; $display("FAIL len_err_pulse: got %b expected 1", le32); end
    for (int i = 0; i < 32; i++) strobe(1'b0, 8'h00);
    nchk++; if (v32 !== 1'b1 || synd32 !== 32'h0 || ef32 !== 1'b1) begin
      nerr++; $display("FAIL len_err_frame: valid=%b synd=%h ef=%b expected 1/0/1", v32, synd32, ef32); end
    tick();
    nchk++; if (n_len_err - le0 !== 1 || n_vrise - vr0 !== 1) begin
      nerr++; $display("FAIL len_err_counts: len_err=%0d valid=%0d expected 1/1", n_len_err - le0, n_vrise - vr0); end
  endtask

  task automatic test_overflow();
    int ov0;
    ov0 = n_ovf;
    rdy = 1'b0;
    strobe(1'b1, 8'h00);
    for (int i = 1; i < 31; i++) strobe(1'b0, 8'h00);
    strobe(1'b0, 8'h5A);
    idle(3);
    nchk++; if (v32 !== 1'b1 || synd32 !== 32'h5A5A5A5A || ef32 !== 1'b0) begin
      nerr++; $display("FAIL ovf_hold: valid=%b synd=%h ef=%b expected 1/5a5a5a5a/0", v32, synd32, ef32); end
    strobe(1'b1, 8'h00);
    for (int i = 1; i < 32; i++) strobe(1'b0, 8'h00);
    nchk++; if (ovf32 !== 1'b1 || v32 !== 1'b1 || synd32 !== 32'h0 || ef32 !== 1'b1) begin
      nerr++; $display("FAIL ovf_overwrite: ovf=%b valid=%b synd=%h ef=%b expected 1/1/0/1", ovf32, v32, synd32, ef32); end
    tick();
    nchk++; if (ovf32 !== 1'b0 || n_ovf - ov0 !== 1 || v32 !== 1'b1) begin
      nerr++; $display("FAIL ovf_single: ovf=%b pulses=%0d valid=%b expected 0/1/1", ovf32, n_ovf - ov0, v32); end
    rdy = 1'b1;
    tick();
    nchk++; if (v32 !== 1'b0) begin
      nerr++; $display("FAIL ovf_accept: valid=%b expected 0", v32); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_s;
    int ov0, le0;
    ov0 = n_ovf; le0 = n_len_err;
    for (int j = 0; j < 4; j++) exp_s[8*j +: 8] = alpha_pow(31 * j);
    rdy = 1'b0;
    strobe(1'b1, 8'h00);
    for (int i = 1; i < 31; i++) strobe(1'b0, 8'h00);
    strobe(1'b0, 8'h5A);
    // Frame B completes in the same cycle that frame A is accepted.
    // A frame sync on that last strobe opens frame C.
    strobe(1'b1, 8'h01);
    for (int i = 1; i < 31; i++) strobe(1'b0, 8'h00);
    rdy = 1'b1;
    strobe(1'b1, 8'h00);
    nchk++; if (v32 !== 1'b1 || synd32 !== exp_s || ovf32 !== 1'b0 || le32 !== 1'b0) begin
      nerr++; $display("FAIL b2b_complete: valid=%b synd=%h ovf=%b len_err=%b expected 1/%h/0/0", v32, synd32, ovf32, le32, exp_s); end
    for (int i = 0; i < 31; i++) strobe(1'b0, 8'h00);
    nchk++; if (v32 !== 1'b0) begin
      nerr++; $display("FAIL b2b_early: valid=%b expected 0", v32); end
    strobe(1'b0, 8'h00);
    nchk++; if (v32 !== 1'b1 || synd32 !== 32'h0 || ef32 !== 1'b1) begin
      nerr++; $display("FAIL b2b_frame_c: valid=%b synd=%h ef=%b expected 1/0/1", v32, synd32, ef32); end
    tick();
    nchk++; if (n_ovf - ov0 !== 0 || n_len_err - le0 !== 0) begin
      nerr++; $display("FAIL b2b_pulses: ovf=%0d len_err=%0d expected 0/0", n_ovf - ov0, n_len_err - le0); end
  endtask

  task automatic test_mid_reset();
    int vr0, le0;
    rdy = 1'b0;
    strobe(1'b1, 8'h00);
    for (int i = 1; i < 31; i++) strobe(1'b0, 8'h00);
    strobe(1'b0, 8'h5A);
    strobe(1'b1, 8'h33);
    for (int i = 1; i < 20; i++) strobe(1'b0, 8'h33);
    rst = 1'b1;
    strobe(1'b0, 8'h33);
    rst = 1'b0;
    nchk++; if (v32 !== 1'b0 || synd32 !== 32'h0 || ef32 !== 1'b0 || le32 !== 1'b0 || ovf32 !== 1'b0) begin
      nerr++; $display("FAIL mid_reset_out: valid=%b synd=%h ef=%b le=%b ovf=%b expected all 0", v32, synd32, ef32, le32, ovf32); end
    vr0 = n_vrise; le0 = n_len_err;
    rdy = 1'b1;
    for (int i = 21; i < 32; i++) strobe(1'b0, 8'h33);
    idle(2);
    nchk++; if (n_vrise - vr0 !== 0 || n_len_err - le0 !== 0 || st32 !== 2'd0) begin
      nerr++; $display("FAIL mid_reset_tail: valid=%0d len_err=%0d st=%0d expected 0/0/0", n_vrise - vr0, n_len_err - le0, st32); end
    strobe(1'b1, 8'h00);
    for (int i = 1; i < 32; i++) strobe(1'b0, 8'h00);
    nchk++; if (v32 !== 1'b1 || synd32 !== 32'h0 || ef32 !== 1'b1) begin
      nerr++; $display("FAIL mid_reset_recover: valid=%b synd=%h ef=%b expected 1/0/1", v32, synd32, ef32); end
    tick();
  endtask

  task automatic test_nlen28();
    rst = 1'b1; idle(1); rst = 1'b0;
    sync_only();
    for (int i = 0; i < 27; i++) strobe(1'b0, 8'h00);
    nchk++; if (v28 !== 1'b0) begin
      nerr++; $display("FAIL n28_early: valid=%b expected 0", v28); end
    strobe(1'b0, 8'h00);
    nchk++; if (v28 !== 1'b1 || synd28 !== 32'h0 || ef28 !== 1'b1 || v32 !== 1'b0) begin
      nerr++; $display("FAIL n28_frame: valid=%b synd=%h ef=%b valid32=%b expected 1/0/1/0", v28, synd28, ef28, v32); end
    tick();
  endtask

`ifdef RS_SYND_ERASURE_EN
  task automatic test_erasure();
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      era = (i == 3 || i == 10 || i == 31);
      strobe(i == 0, 8'h00);
    end
    era = 1'b0;
    nchk++; if (era_cnt32 !== 6'd3 || synd32 !== 32'h0 || ef32 !== 1'b0 || v32 !== 1'b1) begin
      nerr++; $display("FAIL erasure: cnt=%0d synd=%h ef=%b valid=%b expected 3/0/0/1", era_cnt32, synd32, ef32, v32); end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; fs = 1'b0; dat = 8'h00; ds = 1'b0; rdy = 1'b1;
`ifdef RS_SYND_ERASURE_EN
    era = 1'b0;
`endif
    #2;
    test_reset();
    test_zero_frame();
    test_horner();
    test_len_err();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_nlen28();
`ifdef RS_SYND_ERASURE_EN
    test_erasure();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
